// File: rtl/sos_sched_pkg.sv
// sos_sched_pkg: shared FSM state type, datapath widths and power slice indices
package sos_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;
  localparam int SW   = 27;
  localparam int AW   = 40;
  localparam int PW   = 11;
  localparam int P_LO = 26;
  localparam int P_HI = P_LO + PW - 1;
endpackage

// File: rtl/band_power_acc.sv
// band_power_acc: per-band magnitude accumulation and window power capture
module band_power_acc
  import sos_sched_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          add_i,
  input  logic          win_i,
  input  logic [SW-1:0] smp_i,
  output logic [PW-1:0] pwr_o
);
  logic [SW-1:0] mag;
  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] pwr_q;
  // the most negative sample saturates so its magnitude cannot wrap
  always_comb begin
    mag   = !smp_i[SW-1] ? smp_i : (smp_i == {1'b1, {SW-1{1'b0}}}) ? {1'b0, {SW-1{1'b1}}} : -smp_i;
    acc_d = win_i ? '0 : add_i ? acc_q + AW'(mag) : acc_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_q <= '0;
      pwr_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (win_i) pwr_q <= acc_q[P_HI:P_LO];
    end
  assign pwr_o = pwr_q;
endmodule

// File: rtl/sos_scheduler.sv
// sos_scheduler: time-shares one SOS engine across NUM_BANDS two-section band filters.
// Optional WAIT watchdog with sticky timeout output under SOS_SCHED_TIMEOUT_EN.
module sos_scheduler
  import sos_sched_pkg::*;
#(
  parameter int NUM_BANDS = 6,
  parameter int WINDOW    = 9600,
  parameter int AOWIDTH   = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    aud_strobe,
  input  logic [15:0]             iAud,
  output logic                    sos_start,
  output logic [2:0]              sos_band,
  output logic                    sos_sect,
  output logic [SW-1:0]           sos_in,
  input  logic                    sos_done,
  input  logic [SW-1:0]           sos_out,
  output logic                    band_valid,
  output logic [2:0]              band_id,
  output logic [AOWIDTH:0]        oAud,
  output logic [NUM_BANDS*PW-1:0] power,
  output logic                    power_valid,
  output logic                    overrun,
`ifdef SOS_SCHED_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic                    busy
);
  state_t state_q, state_d;
  logic [2:0] band_q, bid_q;
  logic sect_q, bv_q, pv_q, ovr_q;
  logic [SW-1:0] samp_q, in_q;
  logic [AOWIDTH:0] oaud_q;
  logic [15:0] cnt_q;
  logic [NUM_BANDS*PW-1:0] pwr;
  logic accept, done_w, skip, skip_q, adv, last, seq_end, win;
  assign accept  = state_q == IDLE && enable && aud_strobe;
  assign done_w  = state_q == WAIT && sos_done;
  assign adv     = sect_q | skip_q;
  assign last    = adv && band_q == 3'(NUM_BANDS - 1);
  assign seq_end = state_q == NEXT && last;
  assign win     = seq_end && cnt_q == 16'(WINDOW - 1);
`ifdef SOS_SCHED_TIMEOUT_EN
  logic [5:0] wd_q;
  logic to_q;
  assign skip    = state_q == WAIT && !sos_done && wd_q == 6'd63;
  assign timeout = to_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wd_q   <= '0;
      skip_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      wd_q <= state_q == WAIT ? wd_q + 6'd1 : 6'd0;
      if (state_q == WAIT) skip_q <= skip;
      if (skip) to_q <= 1'b1;
    end
`else
  assign skip   = 1'b0;
  assign skip_q = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb
    state_d = state_q == IDLE  ? (accept ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? ((done_w || skip) ? NEXT : WAIT) :
              (last ? IDLE : ISSUE);
  always_comb begin
    sos_start = state_q == ISSUE;
    busy      = state_q != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      band_q <= '0;
      sect_q <= 1'b0;
      samp_q <= '0;
      in_q   <= '0;
      bv_q   <= 1'b0;
      bid_q  <= '0;
      oaud_q <= '0;
      pv_q   <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      bv_q <= 1'b0;
      pv_q <= win;
      if (aud_strobe && busy) ovr_q <= 1'b1;
      if (accept) begin
        samp_q <= {{3{iAud[15]}}, iAud, 8'd0};
        in_q   <= {{3{iAud[15]}}, iAud, 8'd0};
        band_q <= '0;
        sect_q <= 1'b0;
      end
      // section 1 consumes section 0's result; the next band restarts from the sample
      if (done_w) in_q <= sect_q ? samp_q : sos_out;
      if (skip) in_q <= samp_q;
      if (done_w && sect_q) begin
        bv_q   <= 1'b1;
        bid_q  <= band_q;
        oaud_q <= sos_out[AOWIDTH+11:11];
      end
      if (state_q == NEXT && !last) begin
        sect_q <= !adv;
        band_q <= band_q + {2'b0, adv};
      end
      if (seq_end) cnt_q <= win ? 16'd0 : cnt_q + 16'd1;
    end
  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    band_power_acc u_acc (
      .clk   (clk),
      .reset (reset),
      .add_i (done_w && sect_q && band_q == 3'(b)),
      .win_i (win),
      .smp_i (sos_out),
      .pwr_o (pwr[b*PW +: PW])
    );
  end
  assign sos_band    = band_q;
  assign sos_sect    = sect_q;
  assign sos_in      = in_q;
  assign band_valid  = bv_q;
  assign band_id     = bid_q;
  assign oAud        = oaud_q;
  assign power_valid = pv_q;
  assign overrun     = ovr_q;
  assign power       = (state_q == IDLE && !enable) ? '0 : pwr;
endmodule

// File: tb/tb_sos_scheduler.sv
// tb_sos_scheduler: directed checks of sos_scheduler against a 3-cycle echo/constant engine model
module tb_sos_scheduler;
  logic clk = 0, reset = 1, enable = 1, aud_strobe = 0;
  logic [15:0] iAud = '0;
  logic sos_start, sos_sect, band_valid, power_valid, overrun, busy;
  logic sos_done = 0;
  logic [2:0] sos_band, band_id;
  logic [26:0] sos_in;
  logic [26:0] sos_out = '0;
  logic [13:0] oAud;
  logic [65:0] power;
`ifdef SOS_SCHED_TIMEOUT_EN
  logic timeout;
`endif
  int n_chk = 0, n_pass = 0, n_start = 0, n_bv = 0, n_pv = 0, eng_cd = 0, mode = 0, mute_band = -1;
  int s0, s1, b0, b1, p0;
  logic [26:0] eng_in = '0, const_out = '0;
  logic [3:0] start_log [0:63];

  always #5 clk = ~clk;

  sos_scheduler #(.NUM_BANDS(6), .WINDOW(4), .AOWIDTH(13)) dut (
    .clk(clk), .reset(reset), .enable(enable), .aud_strobe(aud_strobe), .iAud(iAud),
    .sos_start(sos_start), .sos_band(sos_band), .sos_sect(sos_sect), .sos_in(sos_in),
    .sos_done(sos_done), .sos_out(sos_out), .band_valid(band_valid), .band_id(band_id),
    .oAud(oAud), .power(power), .power_valid(power_valid), .overrun(overrun),
`ifdef SOS_SCHED_TIMEOUT_EN
    .timeout(timeout),
`endif
    .busy(busy)
  );

  // engine model: answers each request 3 cycles later, echoing the input or a constant
  always @(negedge clk) begin
    sos_done = 1'b0;
    if (eng_cd > 0) begin
      eng_cd--;
      if (eng_cd == 0) begin
        sos_done = 1'b1;
        sos_out  = mode == 0 ? eng_in : const_out;
      end
    end
    if (sos_start) begin
      start_log[n_start % 64] = {sos_band, sos_sect};
      n_start++;
      eng_in = sos_in;
      if (int'(sos_band) != mute_band) eng_cd = 3;
    end
    if (band_valid) n_bv++;
    if (power_valid) n_pv++;
  end

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    iAud = v;
    aud_strobe = 1;
    @(negedge clk);
    aud_strobe = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_seqs(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(16'h1234);
      wait_idle("idle_seq");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", sos_start, 0);
    chk("rst_power", power, 0);
    chk("rst_oaud", oAud, 0);
    chk("rst_ovr", overrun, 0);
    reset = 0;
    // echo through both sections of all bands
    s0 = n_start; b0 = n_bv;
    strobe(16'h0100);
    wait_idle("idle_echo");
    chk("echo_starts", n_start - s0, 12);
    for (int i = 0; i < 12; i++) chk("echo_order", start_log[(s0 + i) % 64], {3'(i / 2), 1'(i % 2)});
    chk("echo_bv", n_bv - b0, 6);
    chk("echo_oaud", oAud, 14'h0020);
    chk("echo_bid", band_id, 3'd5);
    chk("echo_ovr", overrun, 0);
    // strobe while busy is dropped
    s0 = n_start;
    strobe(16'h0200);
    repeat (5) @(negedge clk);
    strobe(16'h0300);
    wait_idle("idle_ovr");
    chk("ovr_set", overrun, 1);
    chk("ovr_starts", n_start - s0, 12);
    chk("ovr_oaud", oAud, 14'h0040);
    strobe(16'h0400);
    wait_idle("idle_ovr2");
    chk("ovr_next_starts", n_start - s0, 24);
    chk("ovr_next_oaud", oAud, 14'h0080);
    chk("ovr_sticky", overrun, 1);
    // reset while waiting on band 2 section 1
    strobe(16'h0100);
    for (int i = 0; i < 500 && !(sos_start && sos_band == 3'd2 && sos_sect); i++) @(negedge clk);
    chk("found_b2s1", {sos_start, sos_band, sos_sect}, {1'b1, 3'd2, 1'b1});
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_start", sos_start, 0);
    chk("mid_band", sos_band, 0);
    chk("mid_sect", sos_sect, 0);
    chk("mid_in", sos_in, 0);
    chk("mid_oaud", oAud, 0);
    chk("mid_bv", band_valid, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_power", power, 0);
    @(negedge clk);
    #2 reset = 0;
    s1 = n_start; b1 = n_bv;
    repeat (10) @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_starts", n_start - s1, 0);
    chk("stray_bv", n_bv - b1, 0);
    // window power with constant engine output
    mode = 1;
    const_out = 27'h7F00000;
    p0 = n_pv;
    run_seqs(3);
    chk("win_pv3", n_pv - p0, 0);
    run_seqs(1);
    chk("win_pv4", n_pv - p0, 1);
    chk("win_pow_small", power, 0);
    const_out = 27'h1000000;
    run_seqs(4);
    chk("win_pv8", n_pv - p0, 2);
    chk("win_pow_one", power, {6{11'd1}});
    const_out = 27'h4000000;
    run_seqs(4);
    chk("win_pow_sat", power, {6{11'd3}});
    // enable gating
    enable = 0;
    @(negedge clk);
    chk("en_pow_gated", power, 0);
    s0 = n_start;
    strobe(16'h0100);
    repeat (3) @(negedge clk);
    chk("en_busy", busy, 0);
    chk("en_starts", n_start - s0, 0);
    enable = 1;
    @(negedge clk);
    chk("en_pow_back", power, {6{11'd3}});
    strobe(16'h0100);
    enable = 0;
    wait_idle("idle_en_drop");
    chk("en_finish", n_start - s0, 12);
    enable = 1;
`ifdef SOS_SCHED_TIMEOUT_EN
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    mode = 0;
    mute_band = 1;
    s0 = n_start; b0 = n_bv;
    strobe(16'h0100);
    wait_idle("idle_to");
    chk("to_flag", timeout, 1);
    chk("to_starts", n_start - s0, 11);
    chk("to_b1s0", start_log[(s0 + 2) % 64], {3'd1, 1'b0});
    chk("to_b2s0", start_log[(s0 + 3) % 64], {3'd2, 1'b0});
    chk("to_bv", n_bv - b0, 5);
    mute_band = -1;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sos_scheduler.md
SOS_SCHEDULER -- requirements
Module: sos_scheduler

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 6, number of band-pass channels sharing one SOS engine (1..8).
REQ-002 SHALL have parameter WINDOW, default 9600, samples per power-integration window.
REQ-003 SHALL have parameter AOWIDTH, default 13, band sample output MSB index.
REQ-004 SHALL have ports: clk  in  1  single system clock; reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: enable  in  1  run gate; aud_strobe  in  1  one-cycle pulse per audio sample; iAud  in  16  signed audio sample.
REQ-006 SHALL have engine ports: sos_start  out  1  request pulse; sos_band  out  3  band index; sos_sect  out  1  section 0/1; sos_in  out  27  signed section input; sos_done  in  1  result valid pulse; sos_out  in  27  signed section result.
REQ-007 SHALL have result ports: band_valid  out  1  sample-result pulse; band_id  out  3  band index; oAud  out  AOWIDTH+1  signed band sample; power  out  NUM_BANDS*11  packed per-band power; power_valid  out  1  window-end pulse; overrun  out  1  sticky dropped-sample flag; busy  out  1  sequence in progress.

Function
REQ-008 SHALL latch iAud on aud_strobe when enable=1 and state is IDLE, forming sos_in = {3 sign bits, iAud, 8'd0}.
REQ-009 SHALL use FSM states IDLE, ISSUE, WAIT, NEXT; IDLE->ISSUE on accepted strobe; ISSUE->WAIT after one cycle; WAIT->NEXT on sos_done; NEXT->ISSUE if work remains, else IDLE.
REQ-010 SHALL order work band 0..NUM_BANDS-1, section 0 then section 1 per band; section 1 input is the captured section-0 sos_out of the same band.
REQ-011 SHALL assert sos_start for exactly one cycle in ISSUE, with sos_band, sos_sect, sos_in stable from ISSUE until sos_done.
REQ-012 SHALL ignore sos_done outside WAIT.
REQ-013 SHALL, on section-1 sos_done, pulse band_valid next cycle with band_id and oAud = sos_out[24:11] (AOWIDTH=13).
REQ-014 SHALL compute magnitude as two's-complement negation for negative sos_out; -2^26 maps to 2^26-1.
REQ-015 SHALL accumulate magnitude per band into 40-bit unsigned accumulator; a 16-bit shared sample counter increments once per completed sequence.
REQ-016 SHALL, when the counter reaches WINDOW-1 and last band completes, load power[b*11+:11] = acc_b[36:26] for all bands, clear accumulators and counter, pulse power_valid one cycle.
REQ-017 SHALL, on aud_strobe while busy, drop the sample and set overrun, cleared only by reset.
REQ-018 SHALL, on enable deassert, finish the current sequence, then stay IDLE; oAud, band_valid, power hold last values except power forced 0 while enable=0 in IDLE.
REQ-019 SHALL assert busy in every state except IDLE.

Reset
REQ-020 SHALL asynchronously on reset: state IDLE; sos_start, band_valid, power_valid, overrun, busy 0; oAud, power, sos_in, sos_band, sos_sect, accumulators, counter 0.
REQ-021 SHALL abandon any in-flight engine request on reset; a later stray sos_done is ignored per REQ-012.

Configuration
REQ-022 SHALL, with SOS_SCHED_TIMEOUT_EN defined, include a 6-bit WAIT watchdog: 64 cycles without sos_done -> skip remaining sections of that band (no band_valid, no accumulation), set sticky timeout output (out 1), continue with next band.
REQ-023 SHALL, without SOS_SCHED_TIMEOUT_EN, wait indefinitely in WAIT and omit the timeout port.

Structure
REQ-024 SHALL place FSM state enum, 27-bit sample width, 40-bit accumulator width and power slice indices in package sos_sched_pkg.
REQ-025 SHALL implement per-band magnitude/accumulate/window logic in sub-module band_power_acc, one instance per band.

Verification
REQ-026 Reset mid-WAIT, band 2 section 1 -> all outputs 0 within same cycle, IDLE, later sos_done ignored.
REQ-027 Strobe iAud=16'h0100, engine model echoes input after 3 cycles -> 12 starts in order (b0s0,b0s1..b5s1), 6 band_valid, oAud=16'h0100<<8 slice = 14'h0020.
REQ-028 WINDOW=4, sos_out constant -27'd1<<20 -> power_valid after 4th sequence, each power = (4*2^20)>>26 = 0, with 2^24 magnitude power=1.
REQ-029 Strobe during busy -> overrun=1, starts count unchanged, next IDLE strobe accepted.
REQ-030 sos_out=27'h4000000 -> magnitude 27'h3FFFFFF accumulated, no wrap.
REQ-031 SOS_SCHED_TIMEOUT_EN, engine never answers band 1 -> timeout=1 after 64 cycles, band 2 issued next, band 1 no band_valid.
